bbox_unit: RTL and testbench

//  Parametrised triangle bounding-box unit for the rasteriser front end. Accepts three

---
 rtl/bbox_unit.sv | 145 ++++++++++++++
 tb/tb_bbox_unit.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bbox_unit.sv
// Triangle bounding-box unit: captures three signed fixed-point vertices, finds the
// min/max extents, rounds them to whole pixels and clamps them to the screen.
module bbox_unit #(
  parameter int WIDTH    = 16,
  parameter int FRAC     = 6,
  parameter int SCREEN_W = 320,
  parameter int SCREEN_H = 240,
  parameter int OUT_W    = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic signed [WIDTH-1:0] v0x,
  input  logic signed [WIDTH-1:0] v1x,
  input  logic signed [WIDTH-1:0] v2x,
  input  logic signed [WIDTH-1:0] v0y,
  input  logic signed [WIDTH-1:0] v1y,
  input  logic signed [WIDTH-1:0] v2y,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [OUT_W-1:0]        xmin,
  output logic [OUT_W-1:0]        xmax,
  output logic [OUT_W-1:0]        ymin,
  output logic [OUT_W-1:0]        ymax,
  output logic                    cull,
  output logic                    degen
);

  typedef enum logic [2:0] {IDLE, CMP, RND, CLIP, OUT} state_t;

  localparam logic signed [WIDTH:0] HALF  = (WIDTH+1)'(1 << (FRAC - 1));
  localparam logic signed [WIDTH:0] X_LIM = (WIDTH+1)'(SCREEN_W - 1);
  localparam logic signed [WIDTH:0] Y_LIM = (WIDTH+1)'(SCREEN_H - 1);

  state_t state_reg, state_next;

  logic signed [WIDTH-1:0] vx_reg [3];
  logic signed [WIDTH-1:0] vy_reg [3];
  // Extent order everywhere: xmin, xmax, ymin, ymax
  logic signed [WIDTH-1:0] ext_reg  [4];
  logic signed [WIDTH:0]   ext_sx   [4];
  logic signed [WIDTH:0]   sum_next [4];
  logic signed [WIDTH:0]   rnd_next [4];
  logic signed [WIDTH:0]   rnd_reg  [4];
  logic [OUT_W-1:0]        clamp_next [4];
  logic                    degen_reg;
  logic                    cull_next;

  function automatic logic signed [WIDTH-1:0] smin3(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] c
  );
    logic signed [WIDTH-1:0] m;
    m = (a < b) ? a : b;
    return (c < m) ? c : m;
  endfunction

  function automatic logic signed [WIDTH-1:0] smax3(
    input logic signed [WIDTH-1:0] a,
    input logic signed [WIDTH-1:0] b,
    input logic signed [WIDTH-1:0] c
  );
    logic signed [WIDTH-1:0] m;
    m = (a > b) ? a : b;
    return (c > m) ? c : m;
  endfunction

  // One extra bit keeps the half-pixel add from overflowing at the positive limit.
  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_ext
      localparam logic signed [WIDTH:0] LIM = (gi < 2) ? X_LIM : Y_LIM;
      assign ext_sx[gi]     = {ext_reg[gi][WIDTH-1], ext_reg[gi]};
      assign sum_next[gi]   = ext_sx[gi] + HALF;
      assign rnd_next[gi]   = sum_next[gi] >>> FRAC;
      assign clamp_next[gi] = rnd_reg[gi][WIDTH]  ? '0 :
                              (rnd_reg[gi] > LIM) ? LIM[OUT_W-1:0] :
                                                    rnd_reg[gi][OUT_W-1:0];
    end
  endgenerate

  assign cull_next = rnd_reg[1][WIDTH] | (rnd_reg[0] > X_LIM) |
                     rnd_reg[3][WIDTH] | (rnd_reg[2] > Y_LIM);

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = CMP;
      CMP:     state_next = RND;
      RND:     state_next = CLIP;
      CLIP:    state_next = OUT;
      OUT:     if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  assign in_ready  = (state_reg == IDLE) && !rst;
  assign out_valid = (state_reg == OUT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      xmin      <= '0;
      xmax      <= '0;
      ymin      <= '0;
      ymax      <= '0;
      cull      <= 1'b0;
      degen     <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        IDLE: if (in_valid) begin
          vx_reg[0] <= v0x;
          vx_reg[1] <= v1x;
          vx_reg[2] <= v2x;
          vy_reg[0] <= v0y;
          vy_reg[1] <= v1y;
          vy_reg[2] <= v2y;
        end
        CMP: begin
          ext_reg[0] <= smin3(vx_reg[0], vx_reg[1], vx_reg[2]);
          ext_reg[1] <= smax3(vx_reg[0], vx_reg[1], vx_reg[2]);
          ext_reg[2] <= smin3(vy_reg[0], vy_reg[1], vy_reg[2]);
          ext_reg[3] <= smax3(vy_reg[0], vy_reg[1], vy_reg[2]);
        end
        RND: begin
          for (int i = 0; i < 4; i++) rnd_reg[i] <= rnd_next[i];
          degen_reg <= (rnd_next[0] == rnd_next[1]) | (rnd_next[2] == rnd_next[3]);
        end
        CLIP: begin
          xmin  <= clamp_next[0];
          xmax  <= clamp_next[1];
          ymin  <= clamp_next[2];
          ymax  <= clamp_next[3];
          cull  <= cull_next;
          degen <= degen_reg;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_bbox_unit.sv
// Directed bench for bbox_unit: vector table for the box arithmetic plus hand-written
// sequences for back-pressure, back-to-back throughput and mid-flight reset.
module tb_bbox_unit;

  logic clk = 1'b0;
  logic rst;
  logic in_valid, in_ready, out_valid, out_ready;
  logic signed [15:0] v0x, v1x, v2x, v0y, v1y, v2y;
  logic [9:0] xmin, xmax, ymin, ymax;
  logic cull, degen;

  always #5 clk = ~clk;

  bbox_unit dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .v0x(v0x), .v1x(v1x), .v2x(v2x), .v0y(v0y), .v1y(v1y), .v2y(v2y),
    .out_valid(out_valid), .out_ready(out_ready),
    .xmin(xmin), .xmax(xmax), .ymin(ymin), .ymax(ymax),
    .cull(cull), .degen(degen)
  );

  typedef struct {
    int x0, x1, x2, y0, y1, y2;
    int exmin, exmax, eymin, eymax, ecull, edegen;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];
  int tests = 0;
  int fails = 0;
  int cyc_cnt = 0;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    v0x = 16'(v.x0); v1x = 16'(v.x1); v2x = 16'(v.x2);
    v0y = 16'(v.y0); v1y = 16'(v.y1); v2y = 16'(v.y2);
  endtask

  task automatic chk_box(input string tag, input vec_t v);
    chk({tag, " xmin"},  int'(xmin),  v.exmin);
    chk({tag, " xmax"},  int'(xmax),  v.exmax);
    chk({tag, " ymin"},  int'(ymin),  v.eymin);
    chk({tag, " ymax"},  int'(ymax),  v.eymax);
    chk({tag, " cull"},  int'(cull),  v.ecull);
    chk({tag, " degen"}, int'(degen), v.edegen);
  endtask

  // Accept one triangle, check latency and result, then complete the handshake.
  task automatic run_vec(input int idx);
    int n;
    @(negedge clk);
    drive(vecs[idx]);
    in_valid = 1'b1;
    out_ready = 1'b0;
    chk("in_ready_idle", int'(in_ready), 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 1;
    while (!out_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("latency", n, 4);
    chk_box($sformatf("vec%0d", idx), vecs[idx]);
    $display("[TB] vec %0d: box x %0d..%0d y %0d..%0d cull %0d degen %0d", idx,
             xmin, xmax, ymin, ymax, cull, degen);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("idle_after_take", int'(in_ready), 1);
    chk("ov_low_after_take", int'(out_valid), 0);
  endtask

  initial begin
    int n;
    int acc [4];
    vecs[0]  = '{64, 320, 192, 128, 64, 640,        1, 5, 1, 10, 0, 0};
    vecs[1]  = '{95, 96, 96, 0, 0, 64,              1, 2, 0, 1, 0, 0};
    vecs[2]  = '{-128, 25600, 0, -64, 0, 32000,     0, 319, 0, 239, 0, 0};
    vecs[3]  = '{-640, -320, -64, 0, 64, 128,       0, 0, 0, 2, 1, 0};
    vecs[4]  = '{64, 64, 64, 0, 64, 128,            1, 1, 0, 2, 0, 1};
    vecs[5]  = '{-96, 640, 0, 0, 0, 0,              0, 10, 0, 0, 0, 1};
    vecs[6]  = '{0, 64, 128, 15360, 15400, 16000,   0, 2, 239, 239, 1, 0};
    vecs[7]  = '{20480, 20544, 20608, 0, 64, 128,   319, 319, 0, 2, 1, 0};
    vecs[8]  = '{0, 0, 20416, 0, 64, 128,           0, 319, 0, 2, 0, 0};
    vecs[9]  = '{-32768, 32767, 0, 0, 64, 128,      0, 319, 0, 2, 0, 0};
    vecs[10] = '{0, 64, 128, -640, -320, -96,       0, 2, 0, 0, 1, 0};

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    drive(vecs[0]);
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", int'(in_ready), 0);
    chk("rst out_valid", int'(out_valid), 0);
    chk_box("rst", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("post-rst in_ready", int'(in_ready), 1);

    for (int i = 0; i < NV; i++) run_vec(i);

    // Back-pressure: result held for 10 cycles while new inputs are offered.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
    chk("stall ov", int'(out_valid), 1);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      drive(vecs[7]);
      in_valid = k[0];
      @(posedge clk); #1;
      chk("stall ov hold", int'(out_valid), 1);
      chk("stall in_ready", int'(in_ready), 0);
      chk_box("stall", vecs[0]);
    end
    $display("[TB] stall: held 10 cycles, box x %0d..%0d", xmin, xmax);
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    chk("stall release idle", int'(in_ready), 1);
    chk("stall hold xmax", int'(xmax), 5);
    run_vec(1);

    // Back-to-back with out_ready tied high and in_valid held.
    @(negedge clk);
    out_ready = 1'b1;
    drive(vecs[2]);
    in_valid = 1'b1;
    for (int k = 0; k < 4; k++) begin
      n = 0;
      while (!in_ready && n < 20) begin @(negedge clk); n++; end
      acc[k] = cyc_cnt;
      @(posedge clk); #1;
      if (k < 3) drive(vecs[3 + k]); else in_valid = 1'b0;
      n = 1;
      while (!out_valid && n < 20) begin @(posedge clk); #1; n++; end
      chk("b2b latency", n, 4);
      chk_box($sformatf("b2b%0d", k), vecs[2 + k]);
      if (k > 0) chk("b2b period", acc[k] - acc[k-1], 5);
      $display("[TB] b2b %0d: accepted at cycle %0d, box x %0d..%0d y %0d..%0d", k,
               acc[k], xmin, xmax, ymin, ymax);
      @(negedge clk);
    end
    out_ready = 1'b0;
    @(posedge clk); #1;

    // Reset while the triangle is in CMP: nothing is emitted.
    @(negedge clk);
    drive(vecs[0]);
    in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rstcmp in_ready", int'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rstcmp idle", int'(in_ready), 1);
    chk_box("rstcmp", '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0});
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      chk("rstcmp ov", int'(out_valid), 0);
    end
    $display("[TB] reset in CMP: out_valid stayed low, box x %0d..%0d", xmin, xmax);
    run_vec(8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
